// File: rtl/cpu_dbus_responder_pkg.sv
// Shared constants for the CPU data-bus responder: I/O page layout and STATUS bits.
package cpu_dbus_pkg;

    localparam int unsigned IO_WORDS = 16;
    localparam int unsigned IO_OFS_W = 4;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned COUNT_W  = 16;

    // Word offsets inside the I/O page
    localparam logic [IO_OFS_W-1:0] TXDATA = 4'd0;
    localparam logic [IO_OFS_W-1:0] STATUS = 4'd1;
    localparam logic [IO_OFS_W-1:0] RXDATA = 4'd2;
    localparam logic [IO_OFS_W-1:0] COUNT  = 4'd4;

    // STATUS bit positions
    localparam int unsigned STAT_TX_FULL  = 0;
    localparam int unsigned STAT_TX_EMPTY = 1;
    localparam int unsigned STAT_RX_FULL  = 2;
    localparam int unsigned STAT_TX_OVF   = 3;

    // STATUS word payload, packed MSB first so bit positions match the indices above
    typedef struct packed {
        logic tx_ovf;
        logic rx_full;
        logic tx_empty;
        logic tx_full;
    } status_t;

endpackage

// File: rtl/cpu_dbus_responder_if.sv
// CPU data port plus the byte-stream tx/rx handshakes toward the serial peripheral.
interface cpu_dbus_responder_if #(
    parameter int unsigned width       = 16,
    parameter int unsigned daddr_width = 8
);
    logic [daddr_width-1:0] daddr;
    logic                   dwrite;
    logic [width-1:0]       dD;
    logic [width-1:0]       dQ;
    logic [7:0]             tx_data;
    logic                   tx_valid;
    logic                   tx_ready;
    logic [7:0]             rx_data;
    logic                   rx_valid;
    logic                   rx_ready;

    modport master (
        output daddr, dwrite, dD, tx_ready, rx_data, rx_valid,
        input  dQ, tx_data, tx_valid, rx_ready
    );

    modport slave (
        input  daddr, dwrite, dD, tx_ready, rx_data, rx_valid,
        output dQ, tx_data, tx_valid, rx_ready
    );
endinterface

// File: rtl/cpu_dbus_responder_sync_fifo.sv
// Transmit byte FIFO; a push into a full FIFO is accepted when a pop happens the same cycle.
module sync_fifo #(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [width-1:0] push_data_i,
    input  logic             pop_i,
    output logic [width-1:0] head_o,
    output logic             empty_o,
    output logic             full_nxt_o,
    output logic             empty_nxt_o,
    output logic             drop_o
);
    localparam int unsigned PTR_W = $clog2(depth);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [width-1:0] mem_q [depth];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;
    logic             do_push;

    // Accept/pop decisions and pointer/count next state
    always_comb begin
        do_pop   = pop_i & (count_q != '0);
        do_push  = push_i & ((count_q < CNT_W'(depth)) | do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; occupancy alone defines validity
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o      = mem_q[rd_ptr_q];
    assign empty_o     = (count_q == '0);
    assign full_nxt_o  = (count_d == CNT_W'(depth));
    assign empty_nxt_o = (count_d == '0);
    assign drop_o      = push_i & ~do_push;

endmodule

// File: rtl/cpu_dbus_responder.sv
// Serves Forth CPU loads/stores: word RAM below the I/O page, tx FIFO, rx holding register, cycle counter.
module cpu_dbus_responder
    import cpu_dbus_pkg::*;
#(
    parameter int unsigned width       = 16,
    parameter int unsigned daddr_width = 8,
    parameter int unsigned tx_depth    = 4
) (
    input logic                 clk,
    input logic                 reset,
    cpu_dbus_responder_if.slave bus
);
    localparam int unsigned IO_BASE = (1 << daddr_width) - IO_WORDS;

    logic [width-1:0]    ram_q [IO_BASE];
    logic [width-1:0]    dq_q, dq_d;
    logic                ovf_q, ovf_d;
    logic                rx_full_q, rx_full_d;
    logic [BYTE_W-1:0]   rx_byte_q, rx_byte_d;
    logic [COUNT_W-1:0]  cnt_q, cnt_d;

    logic                is_io;
    logic [IO_OFS_W-1:0] io_ofs;
    logic                st_tx, st_status, st_rx, st_count;
    logic                rx_ready_c;
    logic                capture;
    logic [BYTE_W-1:0]   tx_head;
    logic                tx_empty;
    logic                tx_full_nxt, tx_empty_nxt, tx_drop;
    status_t             status_d;

    // The I/O page is the top 16 words: all upper address bits set
    assign is_io     = &bus.daddr[daddr_width-1:IO_OFS_W];
    assign io_ofs    = bus.daddr[IO_OFS_W-1:0];
    assign st_tx     = bus.dwrite & is_io & (io_ofs == TXDATA);
    assign st_status = bus.dwrite & is_io & (io_ofs == STATUS);
    assign st_rx     = bus.dwrite & is_io & (io_ofs == RXDATA);
    assign st_count  = bus.dwrite & is_io & (io_ofs == COUNT);

    sync_fifo #(
        .width (BYTE_W),
        .depth (tx_depth)
    ) u_tx_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (st_tx),
        .push_data_i (bus.dD[BYTE_W-1:0]),
        .pop_i       (bus.tx_ready),
        .head_o      (tx_head),
        .empty_o     (tx_empty),
        .full_nxt_o  (tx_full_nxt),
        .empty_nxt_o (tx_empty_nxt),
        .drop_o      (tx_drop)
    );

    // Held low during reset so no byte is taken while state is being cleared
    assign rx_ready_c = reset & ~rx_full_q;
    assign capture    = bus.rx_valid & rx_ready_c;

    // Next state of the I/O registers and the post-edge view that loads return
    always_comb begin
        ovf_d     = ovf_q;
        rx_full_d = rx_full_q;
        rx_byte_d = rx_byte_q;
        cnt_d     = cnt_q + COUNT_W'(1);

        if (tx_drop) begin
            ovf_d = 1'b1;
        end else if (st_status && bus.dD[STAT_TX_OVF]) begin
            ovf_d = 1'b0;
        end

        if (capture) begin
            rx_full_d = 1'b1;
            rx_byte_d = bus.rx_data;
        end else if (st_rx) begin
            rx_full_d = 1'b0;
            rx_byte_d = '0;
        end

        if (st_count) begin
            cnt_d = COUNT_W'(bus.dD);
        end

        status_d.tx_ovf   = ovf_d;
        status_d.rx_full  = rx_full_d;
        status_d.tx_empty = tx_empty_nxt;
        status_d.tx_full  = tx_full_nxt;
    end

    // Load data mux; RAM is write-first, I/O reflects state after this edge
    always_comb begin
        dq_d = '0;
        if (!is_io) begin
            dq_d = bus.dwrite ? bus.dD : ram_q[bus.daddr];
        end else begin
            case (io_ofs)
                STATUS:  dq_d = width'(status_d);
                RXDATA:  dq_d = width'(rx_byte_d);
                COUNT:   dq_d = width'(cnt_d);
                default: dq_d = '0;
            endcase
        end
    end

    // Resettable registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            dq_q      <= '0;
            ovf_q     <= 1'b0;
            rx_full_q <= 1'b0;
            rx_byte_q <= '0;
            cnt_q     <= '0;
        end else begin
            dq_q      <= dq_d;
            ovf_q     <= ovf_d;
            rx_full_q <= rx_full_d;
            rx_byte_q <= rx_byte_d;
            cnt_q     <= cnt_d;
        end
    end

    // Word RAM, contents survive reset
    always_ff @(posedge clk) begin
        if (bus.dwrite && !is_io) begin
            ram_q[bus.daddr] <= bus.dD;
        end
    end

    assign bus.dQ       = dq_q;
    assign bus.tx_data  = tx_head;
    assign bus.tx_valid = ~tx_empty;
    assign bus.rx_ready = rx_ready_c;

endmodule

// File: tb/tb_cpu_dbus_responder.sv
// Directed plus randomized check of cpu_dbus_responder against a queue/array reference model.
module tb_cpu_dbus_responder;

    logic clk = 1'b0;
    logic reset = 1'b0;

    cpu_dbus_responder_if #(.width(16), .daddr_width(8)) bus ();

    cpu_dbus_responder #(
        .width       (16),
        .daddr_width (8),
        .tx_depth    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] m_ram [bit [7:0]];
    logic [7:0]  m_q [$];
    logic        m_ovf;
    logic        m_rx_full;
    logic [7:0]  m_rx_byte;
    logic [15:0] m_cnt;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic w, input logic [15:0] d);
        bus.daddr  = a;
        bus.dwrite = w;
        bus.dD     = d;
    endtask

    // One clock: advance the model from the current inputs, then compare every visible output
    task automatic step();
        logic [15:0] exp_dq;
        bit          dq_known;
        bit          io;
        bit          pop;
        logic [3:0]  ofs;
        dq_known = 1'b1;
        exp_dq   = 16'h0;
        if (!reset) begin
            m_q.delete();
            m_ovf     = 1'b0;
            m_rx_full = 1'b0;
            m_rx_byte = 8'h0;
            m_cnt     = 16'h0;
        end else begin
            io  = (bus.daddr >= 8'd240);
            ofs = bus.daddr[3:0];
            pop = (m_q.size() != 0) && bus.tx_ready;
            if (pop) void'(m_q.pop_front());
            if (bus.dwrite && io && ofs == 4'd0) begin
                if (m_q.size() < 4) m_q.push_back(bus.dD[7:0]);
                else m_ovf = 1'b1;
            end
            if (bus.dwrite && io && ofs == 4'd1 && bus.dD[3]) m_ovf = 1'b0;
            if (bus.rx_valid && !m_rx_full) begin
                m_rx_full = 1'b1;
                m_rx_byte = bus.rx_data;
            end else if (bus.dwrite && io && ofs == 4'd2) begin
                m_rx_full = 1'b0;
                m_rx_byte = 8'h0;
            end
            m_cnt = (bus.dwrite && io && ofs == 4'd4) ? bus.dD : m_cnt + 16'd1;
            if (!io) begin
                if (bus.dwrite) m_ram[bus.daddr] = bus.dD;
                dq_known = m_ram.exists(bus.daddr);
                if (dq_known) exp_dq = m_ram[bus.daddr];
            end else begin
                case (ofs)
                    4'd1: exp_dq = {12'h0, m_ovf, m_rx_full, m_q.size() == 0, m_q.size() == 4};
                    4'd2: exp_dq = {8'h0, m_rx_byte};
                    4'd4: exp_dq = m_cnt;
                    default: exp_dq = 16'h0;
                endcase
            end
        end
        @(posedge clk);
        #1;
        if (dq_known) chk("dQ", 32'(bus.dQ), 32'(exp_dq));
        chk("tx_valid", 32'(bus.tx_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) chk("tx_data", 32'(bus.tx_data), 32'(m_q[0]));
        chk("rx_ready", 32'(bus.rx_ready), 32'(reset && !m_rx_full));
    endtask

    logic [7:0] drain_exp [4];

    initial begin
        m_ovf = 1'b0; m_rx_full = 1'b0; m_rx_byte = 8'h0; m_cnt = 16'h0;
        drive(8'hF3, 1'b0, 16'h0);
        bus.tx_ready = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h0;

        // Reset state
        reset = 1'b0;
        step(); step();
        chk("rst_dq", 32'(bus.dQ), 32'h0);
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
        chk("rst_rx_ready", 32'(bus.rx_ready), 32'h0);
        reset = 1'b1;
        step();
        chk("rel_rx_ready", 32'(bus.rx_ready), 32'h1);

        // RAM store then load, and same-cycle store/load
        drive(8'h10, 1'b1, 16'h1234); step();
        drive(8'h10, 1'b0, 16'h0);    step();
        chk("ram_load", 32'(bus.dQ), 32'h1234);
        drive(8'h20, 1'b1, 16'hBEEF); step();
        chk("ram_wfirst", 32'(bus.dQ), 32'hBEEF);

        // Fill FIFO past capacity with tx_ready low
        for (int i = 0; i < 5; i++) begin
            drive(8'hF0, 1'b1, 16'(8'hA1 + i)); step();
        end
        drive(8'hF1, 1'b0, 16'h0); step();
        chk("status_full_ovf", 32'(bus.dQ), 32'h0009);
        chk("head_a1", 32'(bus.tx_data), 32'hA1);
        drive(8'hF1, 1'b1, 16'h0008); step();
        chk("status_ovf_clr", 32'(bus.dQ), 32'h0001);

        // Push while popping at full
        bus.tx_ready = 1'b1;
        drive(8'hF0, 1'b1, 16'h00B0); step();
        bus.tx_ready = 1'b0;
        drive(8'hF1, 1'b0, 16'h0); step();
        chk("status_pushpop", 32'(bus.dQ), 32'h0001);
        drain_exp[0] = 8'hA2; drain_exp[1] = 8'hA3; drain_exp[2] = 8'hA4; drain_exp[3] = 8'hB0;
        drive(8'hF3, 1'b0, 16'h0);
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", 32'(bus.tx_data), 32'(drain_exp[i]));
            step();
        end
        bus.tx_ready = 1'b0;
        chk("drained", 32'(bus.tx_valid), 32'h0);

        // Receive path
        bus.rx_data = 8'h5A; bus.rx_valid = 1'b1; step();
        bus.rx_valid = 1'b0;
        chk("rx_full_ready", 32'(bus.rx_ready), 32'h0);
        drive(8'hF2, 1'b0, 16'h0); step();
        chk("rx_load", 32'(bus.dQ), 32'h005A);
        drive(8'hF2, 1'b1, 16'h0); step();
        chk("rx_ack_ready", 32'(bus.rx_ready), 32'h1);

        // Counter wrap
        drive(8'hF4, 1'b1, 16'hFFFE); step();
        drive(8'hF4, 1'b0, 16'h0); step();
        chk("cnt_ffff", 32'(bus.dQ), 32'hFFFF);
        step();
        chk("cnt_wrap", 32'(bus.dQ), 32'h0000);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [7:0] a;
            if ($urandom_range(0, 3) == 0) a = 8'($urandom_range(0, 15));
            else a = 8'hF0 + 8'($urandom_range(0, 15));
            drive(a, $urandom_range(0, 2) == 0, 16'($urandom));
            bus.tx_ready = 1'($urandom);
            bus.rx_valid = 1'($urandom);
            bus.rx_data  = 8'($urandom);
            step();
        end

        // Reset in the middle of traffic with bytes queued and one held
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;
        drive(8'hF2, 1'b1, 16'h0); step();
        drive(8'hF3, 1'b0, 16'h0);
        repeat (5) step();
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(8'hF0, 1'b1, 16'(8'hC0 + i)); step();
        end
        drive(8'hF3, 1'b0, 16'h0);
        bus.rx_data = 8'h77; bus.rx_valid = 1'b1; step();
        bus.rx_valid = 1'b0;
        drive(8'hF1, 1'b0, 16'h0); step();
        chk("pre_rst_status", 32'(bus.dQ), 32'h0004);
        reset = 1'b0;
        step();
        chk("mid_rst_tx_valid", 32'(bus.tx_valid), 32'h0);
        chk("mid_rst_rx_ready", 32'(bus.rx_ready), 32'h0);
        chk("mid_rst_dq", 32'(bus.dQ), 32'h0);
        reset = 1'b1;
        step();
        chk("post_rst_status", 32'(bus.dQ), 32'h0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
